// File: rtl/ins_fetch_queue.sv
// Instruction fetch unit: single-outstanding memory requester feeding a small
// instruction buffer with combinational decode at its head. Optional perf counters: INS_FETCH_QUEUE_PERF_EN.
module ins_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_pc_n,
  input  logic                     pc_write,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [ADDR_W-1:0]        dec_pc,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [4:0]               rd,
  output logic [6:0]               opcode,
  output logic [2:0]               funct3,
  output logic [6:0]               funct7,
  output logic [31:0]              imm32,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
`ifdef INS_FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next, drop_addr;
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count_next;
  logic              push, pop;
  logic [ADDR_W-1:0] pc_mem  [DEPTH];
  logic [31:0]       ins_mem [DEPTH];
  logic [31:0]       ins;

  assign dec_valid = (count != '0);

  // Redirect outranks both buffer operations; a request abandoned by a
  // redirect keeps its old address in DROP until memory acknowledges it.
  always_comb begin
    push       = (state == REQ) && imem_ack && !redirect;
    pop        = dec_valid && dec_ready && !redirect;
    count_next = redirect ? '0 : count + CW'(push) - CW'(pop);
    state_next = state;
    pc_next    = pc;
    imem_req   = 1'b0;
    imem_addr  = pc;
    case (state)
      IDLE: begin
        if (pc_write && (count < FULL) && !redirect) state_next = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          state_next = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          pc_next = pc + ADDR_W'(4);
          if (!(pc_write && (count_next < FULL))) state_next = IDLE;
        end
      end
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr;
        if (imem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (redirect) pc_next = redirect_pc & ~ADDR_W'(3);
  end

  always_ff @(posedge clk or negedge rst_pc_n) begin
    if (!rst_pc_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      count <= count_next;
      if (state == REQ && redirect && !imem_ack) drop_addr <= pc;
      if (redirect) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
      end
    end
  end

  // Buffer storage needs no reset; its contents are masked by dec_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]  <= pc;
      ins_mem[tail] <= imem_rdata;
    end
  end

  always_comb begin
    ins     = dec_valid ? ins_mem[head] : '0;
    dec_pc  = dec_valid ? pc_mem[head] : '0;
    opcode  = ins[6:0];
    rd      = ins[11:7];
    funct3  = ins[14:12];
    rs1     = ins[19:15];
    rs2     = ins[24:20];
    funct7  = ins[31:25];
    imm32   = '0;
    illegal = 1'b0;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
        imm32 = {{20{ins[31]}}, ins[31:20]};
      7'b0100011:
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      7'b1100011:
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {ins[31:12], 12'b0};
      7'b1101111:
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      7'b0110011:
        imm32 = '0;
      default:
        illegal = dec_valid;
    endcase
  end

`ifdef INS_FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk or negedge rst_pc_n) begin
    if (!rst_pc_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (dec_ready && !dec_valid) stall_cnt <= stall_cnt + 32'd1;
      if (redirect)                flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Scoreboard bench for ins_fetch_queue: a behavioural memory answers requests,
// expected buffer entries are queued on accepted acks and compared at the head.
module tb_ins_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] pc, word, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0, rst_pc_n = 1'b0, pc_write = 1'b0;
  logic        imem_req, imem_ack = 1'b0, redirect = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0, redirect_pc = 32'h0, dec_pc, imm32;
  logic        dec_valid, dec_ready = 1'b0, illegal;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [2:0]  count;

  exp_t        q[$];
  exp_t        e;
  int          errors = 0, checks = 0, ack_pct = 100;
  logic        ack_en = 1'b1, stall_on = 1'b0, drop_pending = 1'b0, ack, found;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_pw = 1'b1;
  logic [31:0] stall_addr = 32'h8, exp_pc = RESET_PC, max_addr = 32'h0, prev_addr = 32'h0;

  ins_fetch_queue #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_pc_n(rst_pc_n), .pc_write(pc_write),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .imm32(imm32), .illegal(illegal), .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Memory image: a few hand-encoded instructions, else an addi encoding its own address
  function automatic exp_t lookup(input logic [31:0] a);
    exp_t r;
    r.pc = a;
    r.ill = 1'b0;
    case (a)
      32'h200: begin r.word = 32'hFE010113; {r.rd, r.rs1, r.rs2, r.f3, r.f7, r.op} = {5'd2, 5'd2, 5'd0, 3'd0, 7'h7F, 7'h13}; r.imm = 32'hFFFFFFE0; end
      32'h204: begin r.word = 32'h00512423; {r.rd, r.rs1, r.rs2, r.f3, r.f7, r.op} = {5'd8, 5'd2, 5'd5, 3'd2, 7'h00, 7'h23}; r.imm = 32'h00000008; end
      32'h208: begin r.word = 32'hFE000EE3; {r.rd, r.rs1, r.rs2, r.f3, r.f7, r.op} = {5'd29, 5'd0, 5'd0, 3'd0, 7'h7F, 7'h63}; r.imm = 32'hFFFFFFFC; end
      32'h20C: begin r.word = 32'h123450B7; {r.rd, r.rs1, r.rs2, r.f3, r.f7, r.op} = {5'd1, 5'd8, 5'd3, 3'd5, 7'h09, 7'h37}; r.imm = 32'h12345000; end
      32'h210: begin r.word = 32'hFF9FF06F; {r.rd, r.rs1, r.rs2, r.f3, r.f7, r.op} = {5'd0, 5'd31, 5'd25, 3'd7, 7'h7F, 7'h6F}; r.imm = 32'hFFFFFFF8; end
      32'h214: begin r.word = 32'h002081B3; {r.rd, r.rs1, r.rs2, r.f3, r.f7, r.op} = {5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 7'h33}; r.imm = 32'h0; end
      32'h218: begin r.word = 32'h0000007F; {r.rd, r.rs1, r.rs2, r.f3, r.f7, r.op} = {5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h7F}; r.imm = 32'h0; r.ill = 1'b1; end
      default: begin
        r.word = {a[13:2], 5'd1, 3'd0, 5'd2, 7'h13};
        {r.rd, r.rs1, r.rs2, r.f3, r.f7, r.op} = {5'd2, 5'd1, a[6:2], 3'd0, a[13:7], 7'h13};
        r.imm = {{20{a[13]}}, a[13:2]};
      end
    endcase
    return r;
  endfunction

  // Memory responder plus scoreboard, evaluated away from the active edge
  always @(negedge clk) begin
    if (!rst_pc_n) begin
      q.delete();
      drop_pending = 1'b0;
      exp_pc = RESET_PC;
      prev_req = 1'b0;
      prev_ack = 1'b0;
      prev_pw = 1'b1;
      imem_ack = 1'b0;
    end else begin
      checkOutput("count", count, q.size());
      checkOutput("dec_valid", dec_valid, q.size() != 0);
      if (q.size() != 0) begin
        checkOutput("dec_pc", dec_pc, q[0].pc);
        checkOutput("fields", {rd, rs1, rs2, funct3, funct7, opcode},
                    {q[0].rd, q[0].rs1, q[0].rs2, q[0].f3, q[0].f7, q[0].op});
        checkOutput("imm32", imm32, q[0].imm);
        checkOutput("illegal", illegal, q[0].ill);
      end else begin
        checkOutput("empty_pc_imm", {dec_pc, imm32}, 64'h0);
        checkOutput("empty_fields", {rd, rs1, rs2, funct3, funct7, opcode, illegal}, 64'h0);
      end
      if (prev_req && !prev_ack) begin
        checkOutput("req_hold", imem_req, 1'b1);
        checkOutput("addr_hold", imem_addr, prev_addr);
      end
      if (!prev_req && !prev_pw) checkOutput("no_fetch", imem_req, 1'b0);
      if (imem_req && !drop_pending) checkOutput("room", q.size() < DEPTH, 1'b1);
      if (imem_req && imem_addr > max_addr) max_addr = imem_addr;

      ack = imem_req && ack_en && !(stall_on && imem_addr == stall_addr) &&
            ($urandom_range(99) < ack_pct);
      e = lookup(imem_addr);
      imem_ack = ack;
      imem_rdata = ack ? e.word : $urandom;

      if ((q.size() != 0) && dec_ready && !redirect) void'(q.pop_front());
      if (ack) begin
        if (drop_pending || redirect) drop_pending = 1'b0;
        else begin
          checkOutput("fetch_addr", imem_addr, exp_pc);
          q.push_back(e);
          exp_pc = exp_pc + 32'd4;
        end
      end else if (imem_req && redirect) drop_pending = 1'b1;
      if (redirect) begin
        q.delete();
        exp_pc = redirect_pc & ~32'h3;
      end
      prev_req = imem_req;
      prev_ack = ack;
      prev_pw = pc_write;
      prev_addr = imem_addr;
    end
  end

  task automatic applyStimulus(input logic pw, input logic dr, input logic rdir,
                               input logic [31:0] rpc, input int n);
    pc_write = pw;
    dec_ready = dr;
    redirect = rdir;
    redirect_pc = rpc;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_pc_n = 1'b0;
    @(posedge clk);
    #1 rst_pc_n = 1'b1;
    max_addr = 32'h0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", imem_req, 1'b0);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_valid", dec_valid, 1'b0);
    checkOutput("rst_pc_imm", {dec_pc, imm32}, 64'h0);
    checkOutput("rst_fields", {rd, rs1, rs2, funct3, funct7, opcode, illegal}, 64'h0);
    rst_pc_n = 1'b1;

    // Streaming fetch with an always-ready decoder
    applyStimulus(1, 1, 0, 0, 20);

    // Backpressure: buffer fills and fetching stops at 0xC
    do_reset();
    applyStimulus(1, 0, 0, 0, 20);
    checkOutput("bp_count", count, 4);
    checkOutput("bp_req", imem_req, 1'b0);
    checkOutput("bp_max_addr", max_addr, 32'hC);
    applyStimulus(1, 1, 0, 0, 10);

    // Redirect while the request to 0x8 is stalled
    do_reset();
    stall_on = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
      else applyStimulus(1, 1, 0, 0, 1);
    end
    checkOutput("wait_req8", found, 1'b1);
    applyStimulus(1, 1, 1, 32'h103, 1);
    applyStimulus(1, 1, 0, 0, 3);
    checkOutput("drop_req", imem_req, 1'b1);
    checkOutput("drop_addr", imem_addr, 32'h8);
    checkOutput("drop_count", count, 0);
    stall_on = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req && imem_addr != 32'h8) found = 1'b1;
      else applyStimulus(1, 1, 0, 0, 1);
    end
    checkOutput("wait_after_drop", found, 1'b1);
    checkOutput("redir_addr", imem_addr, 32'h100);

    // Hand-encoded instruction formats, including an illegal opcode
    applyStimulus(1, 1, 1, 32'h200, 1);
    applyStimulus(1, 1, 0, 0, 15);

    // Random traffic with a slow memory and occasional redirects
    ack_pct = 60;
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(99) < 85, $urandom_range(99) < 60,
                    $urandom_range(99) < 4, $urandom_range(32'h3FF), 1);
    ack_pct = 100;

    // Reset in the middle of a stalled request
    ack_en = 1'b0;
    applyStimulus(1, 1, 0, 0, 5);
    checkOutput("pre_rst_req", imem_req, 1'b1);
    rst_pc_n = 1'b0;
    #1;
    checkOutput("mid_rst_req", imem_req, 1'b0);
    checkOutput("mid_rst_addr", imem_addr, RESET_PC);
    checkOutput("mid_rst_count", count, 0);
    checkOutput("mid_rst_valid", dec_valid, 1'b0);
    @(posedge clk);
    #1 rst_pc_n = 1'b1;
    ack_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req) found = 1'b1;
      else applyStimulus(1, 1, 0, 0, 1);
    end
    checkOutput("wait_restart", found, 1'b1);
    checkOutput("restart_addr", imem_addr, RESET_PC);
    applyStimulus(1, 1, 0, 0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
